// File: rtl/alu_arbiter_if.sv
// Requester-side channels of the shared-ALU arbiter: two request/response pairs.
// The arbiter takes the slave modport, the requesters' side is the master modport.
interface alu_arbiter_if #(
    parameter int WIDTH = 8
) ();
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_funsel;
    logic             resp0_valid;
    logic             resp0_ready;
    logic [WIDTH-1:0] resp0_result;
    logic [3:0]       resp0_flags;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_funsel;
    logic             resp1_valid;
    logic             resp1_ready;
    logic [WIDTH-1:0] resp1_result;
    logic [3:0]       resp1_flags;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_funsel, resp0_ready,
        input  req1_valid, req1_a, req1_b, req1_funsel, resp1_ready,
        output req0_ready, resp0_valid, resp0_result, resp0_flags,
        output req1_ready, resp1_valid, resp1_result, resp1_flags
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_funsel, resp0_ready,
        output req1_valid, req1_a, req1_b, req1_funsel, resp1_ready,
        input  req0_ready, resp0_valid, resp0_result, resp0_flags,
        input  req1_ready, resp1_valid, resp1_result, resp1_flags
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters: accept one operation,
// hold the ALU inputs for ALU_LAT+1 cycles, then return result/flags to the winner.
module alu_arbiter #(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    alu_arbiter_if.slave     rq,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_funsel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [3:0]       alu_flags,
    output logic             busy
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] LAT_C = 3'(ALU_LAT);

    state_t           state_r;
    state_t           state_s;
    logic             last_grant_r;
    logic             owner_r;
    logic [2:0]       cnt_r;
    logic             grant_s;
    logic             accept_s;
    logic             exec_done_s;
    logic             resp_take_s;
    logic [1:0]       resp_valid_r;
    logic [WIDTH-1:0] resp_result_r [2];
    logic [3:0]       resp_flags_r  [2];

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant_s = 1'b0;
        if (rq.req0_valid && rq.req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (rq.req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign rq.req0_ready = (state_r == ST_IDLE) && rq.req0_valid && !grant_s;
    assign rq.req1_ready = (state_r == ST_IDLE) && rq.req1_valid &&  grant_s;
    assign accept_s      = rq.req0_ready || rq.req1_ready;
    assign exec_done_s   = (state_r == ST_EXEC) && (cnt_r == LAT_C);
    assign resp_take_s   = (state_r == ST_RESP) &&
                           (owner_r ? rq.resp1_ready : rq.resp0_ready);

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (exec_done_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_EXEC;
                end
            end
            ST_RESP: begin
                if (resp_take_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operation capture, ownership and latency counter; ALU inputs hold while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            cnt_r        <= 3'd0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_funsel   <= 4'd0;
        end else if (accept_s) begin
            last_grant_r <= grant_s;
            owner_r      <= grant_s;
            cnt_r        <= 3'd0;
            alu_a        <= grant_s ? rq.req1_a      : rq.req0_a;
            alu_b        <= grant_s ? rq.req1_b      : rq.req0_b;
            alu_funsel   <= grant_s ? rq.req1_funsel : rq.req0_funsel;
        end else if ((state_r == ST_EXEC) && !exec_done_s) begin
            cnt_r <= cnt_r + 3'd1;
        end
    end

    // Response registers: sampled once at the end of EXEC, held until consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_r     <= 2'b00;
            resp_result_r[0] <= '0;
            resp_result_r[1] <= '0;
            resp_flags_r[0]  <= 4'd0;
            resp_flags_r[1]  <= 4'd0;
        end else if (exec_done_s) begin
            resp_valid_r[owner_r]  <= 1'b1;
            resp_result_r[owner_r] <= alu_out;
            resp_flags_r[owner_r]  <= alu_flags;
        end else if (resp_take_s) begin
            resp_valid_r[owner_r] <= 1'b0;
        end
    end

    assign rq.resp0_valid  = resp_valid_r[0];
    assign rq.resp1_valid  = resp_valid_r[1];
    assign rq.resp0_result = resp_result_r[0];
    assign rq.resp1_result = resp_result_r[1];
    assign rq.resp0_flags  = resp_flags_r[0];
    assign rq.resp1_flags  = resp_flags_r[1];
    assign busy            = (state_r != ST_IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter at ALU_LAT = 1, 0 and 3: directed scenarios then random
// traffic, every cycle compared against an operation-level reference model.
module tb_alu_arbiter;
    localparam int WIDTH = 8;
    localparam int NCYC  = 560;

    logic        clk = 1'b0;
    logic [31:0] cyc = 32'd0;
    int          checks = 0;
    int          errors = 0;
    int          lanes_done = 0;

    always #5 clk = ~clk;

    // Free-running cycle count; also drives the stand-in ALU flag vector.
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check_eq(input int lat, input string tag,
                            input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lat%0d %s @%0t: got 0x%0h, expected 0x%0h", lat, tag, $time, act, exp);
        end
    endtask

    // Stand-in ALU combinational result.
    function automatic logic [7:0] alu_fn(input logic [3:0] f, input logic [7:0] a,
                                          input logic [7:0] b);
        case (f)
            4'b0100: alu_fn = a + b;
            4'b0101: alu_fn = a - b;
            4'b0111: alu_fn = a & b;
            4'b1000: alu_fn = a | b;
            default: alu_fn = a ^ b;
        endcase
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : lane
            localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

            logic       reset;
            logic [7:0] alu_a, alu_b, alu_out;
            logic [3:0] alu_funsel, alu_flags;
            logic       busy;

            alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

            assign alu_out   = alu_fn(alu_funsel, alu_a, alu_b);
            assign alu_flags = cyc[3:0];

            alu_arbiter #(.WIDTH(WIDTH), .ALU_LAT(LAT)) dut (
                .clk        (clk),
                .reset      (reset),
                .rq         (bus),
                .alu_a      (alu_a),
                .alu_b      (alu_b),
                .alu_funsel (alu_funsel),
                .alu_out    (alu_out),
                .alu_flags  (alu_flags),
                .busy       (busy)
            );

            initial begin : stim
                logic       pend [2];
                logic [7:0] pa [2];
                logic [7:0] pb [2];
                logic [3:0] pf [2];
                logic       rr [2];
                logic       v  [2];
                logic       m_have, m_owner, m_last, gw, er0, er1, ev0, ev1;
                int         m_vis, c;
                logic [7:0] m_eres, m_a, m_b;
                logic [3:0] m_eflg, m_f;
                logic [7:0] m_res [2];
                logic [3:0] m_flg [2];

                reset = 1'b1;
                bus.req0_valid = 1'b0; bus.req0_a = 8'd0; bus.req0_b = 8'd0; bus.req0_funsel = 4'd0;
                bus.req1_valid = 1'b0; bus.req1_a = 8'd0; bus.req1_b = 8'd0; bus.req1_funsel = 4'd0;
                bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
                for (int n = 0; n < 2; n++) begin
                    pend[n] = 1'b0; pa[n] = 8'd0; pb[n] = 8'd0; pf[n] = 4'd0;
                    m_res[n] = 8'd0; m_flg[n] = 4'd0;
                end
                m_have = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_vis = 0;
                m_eres = 8'd0; m_eflg = 4'd0; m_a = 8'd0; m_b = 8'd0; m_f = 4'd0;

                for (int i = 0; i < NCYC; i++) begin
                    @(negedge clk);
                    reset = (i < 2) || (i == 62) || (i >= 130 && $urandom_range(63) == 0);
                    rr[0] = !((i >= 40 && i < 52) || (i >= 60 && i < 65));
                    rr[1] = 1'b1;
                    case (i)
                        2:  begin pend[0] = 1'b1; pa[0] = 8'h33; pb[0] = 8'h0F; pf[0] = 4'b0100; end
                        14: begin
                            pend[0] = 1'b1; pa[0] = 8'hAA; pb[0] = 8'hF0; pf[0] = 4'b0111;
                            pend[1] = 1'b1; pa[1] = 8'hAA; pb[1] = 8'hF0; pf[1] = 4'b1000;
                        end
                        40: begin pend[0] = 1'b1; pa[0] = 8'h07; pb[0] = 8'hFA; pf[0] = 4'b0101; end
                        42: begin pend[1] = 1'b1; pa[1] = 8'h10; pb[1] = 8'h20; pf[1] = 4'b0100; end
                        60: begin pend[0] = 1'b1; pa[0] = 8'h5A; pb[0] = 8'h0F; pf[0] = 4'b0000; end
                        65: begin
                            pend[0] = 1'b1; pa[0] = 8'h01; pb[0] = 8'h02; pf[0] = 4'b0100;
                            pend[1] = 1'b1; pa[1] = 8'h09; pb[1] = 8'h03; pf[1] = 4'b0101;
                        end
                        default: ;
                    endcase
                    // Keep both requesters saturated so ties alternate.
                    if (i > 14 && i < 28) begin
                        pend[0] = 1'b1;
                        pend[1] = 1'b1;
                    end
                    // Only requester 1 busy, always ready for its response.
                    if (i >= 80 && i < 130 && !pend[1]) begin
                        pend[1] = 1'b1;
                        pa[1] = 8'($urandom_range(255)); pb[1] = 8'($urandom_range(255));
                        pf[1] = 4'($urandom_range(15));
                    end
                    if (i >= 130) begin
                        for (int n = 0; n < 2; n++) begin
                            if (!pend[n] && $urandom_range(2) == 0) begin
                                pend[n] = 1'b1;
                                pa[n] = 8'($urandom_range(255)); pb[n] = 8'($urandom_range(255));
                                pf[n] = 4'($urandom_range(15));
                            end
                            rr[n] = ($urandom_range(3) != 0);
                        end
                    end
                    for (int n = 0; n < 2; n++) begin
                        v[n] = pend[n] && !reset && (i < 130 || $urandom_range(3) != 0);
                    end
                    bus.req0_valid = v[0]; bus.req0_a = pa[0]; bus.req0_b = pb[0]; bus.req0_funsel = pf[0];
                    bus.req1_valid = v[1]; bus.req1_a = pa[1]; bus.req1_b = pb[1]; bus.req1_funsel = pf[1];
                    bus.resp0_ready = rr[0]; bus.resp1_ready = rr[1];
                    #1;
                    c = int'(cyc);

                    // Expected handshake: idle arbiter serves a lone requester, else the one not served last.
                    er0 = 1'b0; er1 = 1'b0;
                    if (!m_have && (v[0] || v[1])) begin
                        gw  = (v[0] && v[1]) ? !m_last : v[1];
                        er0 = !gw;
                        er1 = gw;
                    end
                    if (m_have && c == m_vis) begin
                        m_res[m_owner] = m_eres;
                        m_flg[m_owner] = m_eflg;
                    end
                    ev0 = m_have && !m_owner && (c >= m_vis);
                    ev1 = m_have &&  m_owner && (c >= m_vis);

                    check_eq(LAT, "req0_ready",   32'(bus.req0_ready),   32'(er0));
                    check_eq(LAT, "req1_ready",   32'(bus.req1_ready),   32'(er1));
                    check_eq(LAT, "resp0_valid",  32'(bus.resp0_valid),  32'(ev0));
                    check_eq(LAT, "resp1_valid",  32'(bus.resp1_valid),  32'(ev1));
                    check_eq(LAT, "resp0_result", 32'(bus.resp0_result), 32'(m_res[0]));
                    check_eq(LAT, "resp1_result", 32'(bus.resp1_result), 32'(m_res[1]));
                    check_eq(LAT, "resp0_flags",  32'(bus.resp0_flags),  32'(m_flg[0]));
                    check_eq(LAT, "resp1_flags",  32'(bus.resp1_flags),  32'(m_flg[1]));
                    check_eq(LAT, "alu_a",        32'(alu_a),            32'(m_a));
                    check_eq(LAT, "alu_b",        32'(alu_b),            32'(m_b));
                    check_eq(LAT, "alu_funsel",   32'(alu_funsel),       32'(m_f));
                    check_eq(LAT, "busy",         32'(busy),             32'(m_have));

                    // Advance the model to the state after the coming clock edge.
                    if (reset) begin
                        m_have = 1'b0; m_last = 1'b1;
                        m_a = 8'd0; m_b = 8'd0; m_f = 4'd0;
                        for (int n = 0; n < 2; n++) begin
                            m_res[n] = 8'd0; m_flg[n] = 4'd0;
                        end
                    end else if (m_have) begin
                        if (c >= m_vis && rr[m_owner]) m_have = 1'b0;
                    end else if (er0 || er1) begin
                        m_owner = er1;
                        m_last  = er1;
                        m_a = pa[er1]; m_b = pb[er1]; m_f = pf[er1];
                        m_eres = alu_fn(pf[er1], pa[er1], pb[er1]);
                        // Flags are whatever the ALU shows just before the last EXEC edge.
                        m_eflg = 4'((c + LAT + 1) % 16);
                        m_vis  = c + LAT + 2;
                        m_have = 1'b1;
                        pend[er1] = 1'b0;
                    end
                end
                lanes_done++;
            end
        end
    endgenerate

    initial begin
        for (int k = 0; k < NCYC + 100 && lanes_done < 3; k++) @(posedge clk);
        check_eq(-1, "lanes_done", 32'(lanes_done), 32'd3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
